// File: rtl/ci_dma_controller.sv
// Burst DMA between CI memory and the bus, in either direction; one word per cycle, memory reads one cycle ahead.
// busyIn stalls the outgoing stream with no word lost; busErrorIn aborts through ERROR back to IDLE.
module ci_dma_controller #(
    parameter int MEM_AW = 9,
    parameter int BUS_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfgWe,
    input  logic [2:0]        cfgSel,
    input  logic [31:0]       cfgData,
    output logic [31:0]       cfgResult,
    output logic [MEM_AW-1:0] memAddr,
    output logic              memWe,
    output logic [BUS_W-1:0]  memWData,
    input  logic [BUS_W-1:0]  memRData,
    output logic              requestBus,
    output logic              beginTransaction,
    output logic              readNotWrite,
    output logic              endTransactionOut,
    output logic              dataValidOut,
    output logic [31:0]       addressData,
    output logic [7:0]        burstSize,
    input  logic              busGrant,
    input  logic              endTransactionIn,
    input  logic              dataValidIn,
    input  logic              busyIn,
    input  logic              busErrorIn,
    input  logic [31:0]       dataIn
);
    typedef enum logic [2:0] {S_IDLE, S_REQUEST, S_BEGIN, S_READ, S_WRITE, S_END, S_ERROR} state_t;
    state_t state, state_nxt;

    logic [31:0]       bus_start;
    logic [MEM_AW-1:0] mem_start;
    logic [9:0]        block_size;
    logic [7:0]        burst_len;
    logic [9:0]        remaining;
    logic [8:0]        burst_cnt;
    logic [8:0]        burst_words;
    logic              error;
    logic              to_mem;

    logic       busy, start, abort, rd_take, wr_take, last_word;
    logic [9:0] rem_m1;
    logic [7:0] burst_sz;

    assign busy      = (state != S_IDLE);
    assign start     = cfgWe && !busy && (cfgSel == 3'd5) && (cfgData[0] || cfgData[1]);
    assign abort     = busy && busErrorIn && (state != S_ERROR);
    assign rem_m1    = remaining - 10'd1;
    assign burst_sz  = (rem_m1 < {2'b00, burst_len}) ? rem_m1[7:0] : burst_len;
    assign rd_take   = (state == S_READ) && dataValidIn && !busErrorIn && (remaining != 10'd0);
    assign wr_take   = (state == S_WRITE) && !busyIn && !busErrorIn;
    assign last_word = ((burst_cnt + 9'd1) == burst_words);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_ERROR;
        end else begin
            case (state)
                S_IDLE:    if (start && block_size != 10'd0) state_nxt = S_REQUEST;
                S_REQUEST: if (busGrant) state_nxt = S_BEGIN;
                S_BEGIN:   state_nxt = to_mem ? S_READ : S_WRITE;
                S_READ:    if (endTransactionIn) state_nxt = S_END;
                S_WRITE:   if (wr_take && last_word) state_nxt = S_END;
                S_END:     state_nxt = (remaining != 10'd0) ? S_REQUEST : S_IDLE;
                S_ERROR:   state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // memAddr runs one word ahead of an accepted write so the next word is already on memRData
    always_comb begin
        requestBus        = 1'b0;
        beginTransaction  = 1'b0;
        readNotWrite      = 1'b0;
        endTransactionOut = 1'b0;
        dataValidOut      = 1'b0;
        addressData       = 32'd0;
        burstSize         = 8'd0;
        memAddr           = mem_start;
        memWe             = 1'b0;
        memWData          = BUS_W'(dataIn);
        case (state)
            S_REQUEST: requestBus = 1'b1;
            S_BEGIN: begin
                requestBus       = 1'b1;
                beginTransaction = 1'b1;
                addressData      = bus_start;
                burstSize        = burst_sz;
                readNotWrite     = to_mem;
            end
            S_READ: begin
                requestBus = 1'b1;
                memWe      = rd_take;
            end
            S_WRITE: begin
                requestBus   = 1'b1;
                dataValidOut = !busyIn;
                addressData  = 32'(memRData);
                if (wr_take) memAddr = mem_start + MEM_AW'(1);
            end
            S_END:   endTransactionOut = !to_mem;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_start   <= 32'd0;
            mem_start   <= '0;
            block_size  <= 10'd0;
            burst_len   <= 8'd0;
            remaining   <= 10'd0;
            burst_cnt   <= 9'd0;
            burst_words <= 9'd0;
            error       <= 1'b0;
            to_mem      <= 1'b0;
        end else begin
            if (cfgWe && !busy) begin
                case (cfgSel)
                    3'd1:    bus_start  <= cfgData;
                    3'd2:    mem_start  <= cfgData[MEM_AW-1:0];
                    3'd3:    block_size <= cfgData[9:0];
                    3'd4:    burst_len  <= cfgData[7:0];
                    default: ;
                endcase
            end
            if (start) begin
                error     <= 1'b0;
                to_mem    <= cfgData[0];
                remaining <= block_size;
            end
            if (state == S_BEGIN) begin
                burst_cnt   <= 9'd0;
                burst_words <= {1'b0, burst_sz} + 9'd1;
            end
            if (rd_take || wr_take) begin
                mem_start <= mem_start + MEM_AW'(1);
                remaining <= remaining - 10'd1;
                burst_cnt <= burst_cnt + 9'd1;
            end
            if (state == S_END) bus_start <= bus_start + {21'd0, burst_cnt, 2'b00};
            if (abort) error <= 1'b1;
        end
    end

    always_comb begin
        cfgResult = 32'd0;
        case (cfgSel)
            3'd1:    cfgResult = bus_start;
            3'd2:    cfgResult = {{(32-MEM_AW){1'b0}}, mem_start};
            3'd3:    cfgResult = {22'd0, block_size};
            3'd4:    cfgResult = {24'd0, burst_len};
            3'd5:    cfgResult = {30'd0, error, busy};
            default: cfgResult = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_ci_dma_controller.sv
// Bench for ci_dma_controller: reactive bus slave, synchronous CI memory model and scoreboard queues.
module tb_ci_dma_controller;
    logic        clock, reset, cfgWe;
    logic [2:0]  cfgSel;
    logic [31:0] cfgData, cfgResult;
    logic [8:0]  memAddr;
    logic        memWe;
    logic [31:0] memWData, memRData;
    logic        requestBus, beginTransaction, readNotWrite, endTransactionOut, dataValidOut;
    logic [31:0] addressData;
    logic [7:0]  burstSize;
    logic        busGrant, endTransactionIn, dataValidIn, busyIn, busErrorIn;
    logic [31:0] dataIn;

    typedef struct {logic [31:0] addr; logic [7:0] size; logic rnw;} burst_t;
    typedef struct {logic [8:0] addr; logic [31:0] dat;} mw_t;
    burst_t      burst_q[$];
    mw_t         mem_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] rd_q[$];

    int n_chk = 0, n_err = 0;
    int exp_maddr = 0, err_word = -1, stall_lo = -1, stall_hi = -2, wcyc = 0, words_seen = 0;

    logic [31:0] mem [512];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_addr = 9'd0;
    logic [31:0] pre_dat = 32'd0;

    ci_dma_controller #(.MEM_AW(9), .BUS_W(32)) dut (
        .clock(clock), .reset(reset), .cfgWe(cfgWe), .cfgSel(cfgSel), .cfgData(cfgData),
        .cfgResult(cfgResult), .memAddr(memAddr), .memWe(memWe), .memWData(memWData),
        .memRData(memRData), .requestBus(requestBus), .beginTransaction(beginTransaction),
        .readNotWrite(readNotWrite), .endTransactionOut(endTransactionOut),
        .dataValidOut(dataValidOut), .addressData(addressData), .burstSize(burstSize),
        .busGrant(busGrant), .endTransactionIn(endTransactionIn), .dataValidIn(dataValidIn),
        .busyIn(busyIn), .busErrorIn(busErrorIn), .dataIn(dataIn)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (pre_we)     mem[pre_addr] <= pre_dat;
        else if (memWe) mem[memAddr]  <= memWData;
        memRData <= mem[memAddr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave: grants on request, answers read bursts from rd_q, stalls write bursts by schedule
    initial begin : slave
        burst_t b;
        mw_t    mw;
        int     rd_left, rd_idx, wr_left;
        bit     rd_active, wr_active, end_pending, err_pending;
        rd_left = 0; rd_idx = 0; wr_left = 0;
        rd_active = 0; wr_active = 0; end_pending = 0; err_pending = 0;
        busGrant = 0; endTransactionIn = 0; dataValidIn = 0; busyIn = 0; busErrorIn = 0; dataIn = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                rd_active = 0; wr_active = 0; end_pending = 0; err_pending = 0;
                busGrant = 0; endTransactionIn = 0; dataValidIn = 0; busyIn = 0; busErrorIn = 0;
                continue;
            end
            busGrant = requestBus;
            dataValidIn = 0; endTransactionIn = 0; busErrorIn = 0; busyIn = 0;
            if (rd_active) begin
                if (rd_idx == err_word) begin
                    busErrorIn = 1; rd_active = 0; err_pending = 1;
                end else begin
                    dataValidIn = 1;
                    if (rd_q.size() > 0) dataIn = rd_q.pop_front();
                    else                 dataIn = 32'hDEAD_0000;
                    mem_q.push_back('{9'(exp_maddr), dataIn});
                    exp_maddr = (exp_maddr + 1) % 512;
                    rd_idx++; rd_left--;
                    if (rd_left == 0) begin endTransactionIn = 1; rd_active = 0; end
                end
            end
            if (wr_active) begin
                busyIn = (wcyc >= stall_lo && wcyc <= stall_hi);
                wcyc++;
            end
            #1;
            if (err_pending && !busErrorIn) begin
                chk("abort requestBus", 32'(requestBus), 32'd0);
                chk("abort memWe", 32'(memWe), 32'd0);
                err_pending = 0;
            end
            if (end_pending) begin
                chk("endTransactionOut", 32'(endTransactionOut), 32'd1);
                end_pending = 0;
            end
            if (memWe) begin
                chk("mem write expected", 32'(mem_q.size() > 0), 32'd1);
                if (mem_q.size() > 0) begin
                    mw = mem_q.pop_front();
                    chk("mem addr", 32'(memAddr), 32'(mw.addr));
                    chk("mem data", memWData, mw.dat);
                end
            end
            if (wr_active && busyIn) begin
                chk("stall dataValidOut", 32'(dataValidOut), 32'd0);
                if (wr_q.size() > 0) chk("stall data hold", addressData, wr_q[0]);
            end
            if (dataValidOut) begin
                words_seen++;
                chk("bus word expected", 32'(wr_q.size() > 0), 32'd1);
                if (wr_q.size() > 0) chk("bus word", addressData, wr_q.pop_front());
                wr_left--;
                if (wr_left == 0) begin wr_active = 0; end_pending = 1; end
            end
            if (beginTransaction) begin
                chk("burst expected", 32'(burst_q.size() > 0), 32'd1);
                if (burst_q.size() > 0) begin
                    b = burst_q.pop_front();
                    chk("burst addr", addressData, b.addr);
                    chk("burst size", 32'(burstSize), 32'(b.size));
                    chk("burst dir", 32'(readNotWrite), 32'(b.rnw));
                end
                if (readNotWrite) begin rd_active = 1; rd_left = int'(burstSize) + 1; rd_idx = 0; end
                else              begin wr_active = 1; wr_left = int'(burstSize) + 1; end
            end
        end
    end

    // Callers sit between a falling and the next rising edge
    task automatic cfg_wr(input logic [2:0] sel, input logic [31:0] d);
        cfgWe = 1'b1; cfgSel = sel; cfgData = d;
        @(negedge clock);
        cfgWe = 1'b0;
    endtask

    task automatic cfg_rd_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        cfgSel = sel;
        #1;
        chk(tag, cfgResult, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        cfgSel = 3'd5;
        @(negedge clock); #1;
        while (cfgResult[0] && n < 300) begin
            @(negedge clock); #1;
            n++;
        end
        chk(tag, 32'(cfgResult[0]), 32'd0);
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, " bursts left"}, 32'(burst_q.size()), 32'd0);
        chk({tag, " mem writes left"}, 32'(mem_q.size()), 32'd0);
        chk({tag, " bus words left"}, 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0; cfgWe = 1'b0; cfgSel = 3'd0; cfgData = 32'd0;
        repeat (2) @(negedge clock);
        for (int s = 1; s <= 5; s++) cfg_rd_chk($sformatf("reset cfg sel%0d", s), 3'(s), 32'd0);
        chk("reset requestBus", 32'(requestBus), 32'd0);
        chk("reset memWe", 32'(memWe), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // bus-to-memory, single burst
        cfg_wr(3'd1, 32'h0000_1000);
        cfg_wr(3'd2, 32'd1);
        cfg_wr(3'd3, 32'd4);
        cfg_wr(3'd4, 32'd3);
        cfg_rd_chk("s1 busStart readback", 3'd1, 32'h0000_1000);
        burst_q.push_back('{32'h0000_1000, 8'd3, 1'b1});
        for (int i = 0; i < 4; i++) rd_q.push_back(32'hA0 + 32'(i));
        exp_maddr = 1;
        cfg_wr(3'd5, 32'd1);
        wait_idle("s1 idle");
        cfg_rd_chk("s1 busStart advanced", 3'd1, 32'h0000_1010);
        cfg_rd_chk("s1 memStart advanced", 3'd2, 32'd5);
        cfg_rd_chk("s1 status", 3'd5, 32'd0);
        queues_empty("s1");

        // memory-to-bus, two bursts, stall mid-burst, writes while busy ignored
        for (int i = 0; i < 8; i++) preload(9'(2 + i), 32'h11 + 32'(i));
        cfg_wr(3'd1, 32'h0000_2000);
        cfg_wr(3'd2, 32'd2);
        cfg_wr(3'd3, 32'd8);
        cfg_wr(3'd4, 32'd3);
        burst_q.push_back('{32'h0000_2000, 8'd3, 1'b0});
        burst_q.push_back('{32'h0000_2010, 8'd3, 1'b0});
        for (int i = 0; i < 8; i++) wr_q.push_back(32'h11 + 32'(i));
        wcyc = 0; stall_lo = 2; stall_hi = 4; words_seen = 0;
        cfg_wr(3'd5, 32'd2);
        cfg_wr(3'd3, 32'd7);
        cfg_wr(3'd5, 32'd1);
        wait_idle("s2 idle");
        stall_lo = -1; stall_hi = -2;
        chk("s2 words moved", 32'(words_seen), 32'd8);
        cfg_rd_chk("s2 blockSize unchanged", 3'd3, 32'd8);
        cfg_rd_chk("s2 busStart advanced", 3'd1, 32'h0000_2020);
        cfg_rd_chk("s2 memStart advanced", 3'd2, 32'd10);
        queues_empty("s2");

        // memory and bus address wrap, burst truncated to the block
        cfg_wr(3'd1, 32'hFFFF_FFF8);
        cfg_wr(3'd2, 32'd510);
        cfg_wr(3'd3, 32'd5);
        cfg_wr(3'd4, 32'd255);
        burst_q.push_back('{32'hFFFF_FFF8, 8'd4, 1'b1});
        for (int i = 0; i < 5; i++) rd_q.push_back(32'hB0 + 32'(i));
        exp_maddr = 510;
        cfg_wr(3'd5, 32'd1);
        wait_idle("s3 idle");
        cfg_rd_chk("s3 busStart wrapped", 3'd1, 32'h0000_000C);
        cfg_rd_chk("s3 memStart wrapped", 3'd2, 32'd3);
        queues_empty("s3");

        // bus error on the second read word, then a restart clears error
        cfg_wr(3'd1, 32'h0000_3000);
        cfg_wr(3'd2, 32'd20);
        cfg_wr(3'd3, 32'd4);
        cfg_wr(3'd4, 32'd3);
        burst_q.push_back('{32'h0000_3000, 8'd3, 1'b1});
        for (int i = 0; i < 4; i++) rd_q.push_back(32'hC0 + 32'(i));
        exp_maddr = 20; err_word = 1;
        cfg_wr(3'd5, 32'd1);
        wait_idle("s4 idle after abort");
        cfg_rd_chk("s4 error status", 3'd5, 32'd2);
        err_word = -1;
        rd_q.delete();
        burst_q.push_back('{32'h0000_3000, 8'd3, 1'b1});
        for (int i = 0; i < 4; i++) rd_q.push_back(32'hD0 + 32'(i));
        exp_maddr = 21;
        cfg_wr(3'd5, 32'd1);
        cfg_rd_chk("s4 error cleared on start", 3'd5, 32'd1);
        wait_idle("s4 idle after restart");
        cfg_rd_chk("s4 busStart", 3'd1, 32'h0000_3010);
        queues_empty("s4");

        // reset asserted in the middle of a write burst
        cfg_wr(3'd1, 32'h0000_4000);
        cfg_wr(3'd2, 32'd5);
        cfg_wr(3'd3, 32'd5);
        cfg_wr(3'd4, 32'd7);
        burst_q.push_back('{32'h0000_4000, 8'd4, 1'b0});
        for (int i = 0; i < 5; i++) wr_q.push_back(32'h14 + 32'(i));
        words_seen = 0;
        cfg_wr(3'd5, 32'd2);
        for (int i = 0; i < 50 && words_seen < 2; i++) begin
            @(negedge clock); #2;
        end
        chk("s5 words before reset", 32'(words_seen), 32'd2);
        reset = 1'b0;
        #1;
        chk("s5 reset ctl outs", 32'({requestBus, beginTransaction, readNotWrite,
                                      endTransactionOut, dataValidOut, memWe}), 32'd0);
        chk("s5 reset addressData", addressData, 32'd0);
        chk("s5 reset burstSize", 32'(burstSize), 32'd0);
        chk("s5 reset memAddr", 32'(memAddr), 32'd0);
        wr_q.delete();
        burst_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cfg_rd_chk("s5 status after reset", 3'd5, 32'd0);
        cfg_rd_chk("s5 busStart after reset", 3'd1, 32'd0);
        cfg_rd_chk("s5 blockSize after reset", 3'd3, 32'd0);
        cfg_wr(3'd5, 32'd1);
        cfg_rd_chk("s5 zero-size start status", 3'd5, 32'd0);
        @(negedge clock); #1;
        chk("s5 zero-size requestBus", 32'(requestBus), 32'd0);
        queues_empty("s5");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ci_dma_controller.md
CI_DMA_CONTROLLER -- requirements
Module: ci_dma_controller

Interface
REQ-001 SHALL have parameter MEM_AW, default 9, giving the CI-memory word-address width (512 words).
REQ-002 SHALL have parameter BUS_W, default 32, giving the bus and memory data width.
REQ-003 SHALL have port clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfgWe  in  1  one-cycle configuration write strobe from the CI decoder.
REQ-006 SHALL have port cfgSel  in  3  register select for configuration writes and reads.
REQ-007 SHALL have port cfgData  in  32  configuration write data.
REQ-008 SHALL have port cfgResult  out  32  combinational readback of the register selected by cfgSel.
REQ-009 SHALL have ports memAddr (out, MEM_AW), memWe (out, 1), memWData (out, BUS_W) and memRData (in, BUS_W) forming the CI-memory second port, with read data valid one cycle after the address.
REQ-010 SHALL have outputs requestBus, beginTransaction, readNotWrite, endTransactionOut and dataValidOut (1 bit each), addressData (32) and burstSize (8).
REQ-011 SHALL have inputs busGrant, endTransactionIn, dataValidIn, busyIn and busErrorIn (1 bit each), and dataIn (32).

Function
REQ-012 SHALL decode cfgSel 1 as busStart (32b), 2 as memStart (MEM_AW b), 3 as blockSize (10b, words), 4 as burstLen (8b, burst of value+1 words) and 5 as control; write bit0=1 starts a bus-to-memory transfer, bit1=1 starts a memory-to-bus transfer, and bit0 takes priority if both are set.
REQ-013 SHALL return {30'b0, error, busy} on cfgResult when cfgSel=5, and the zero-extended register value for selects 1-4.
REQ-014 SHALL ignore configuration writes and start requests while busy=1.
REQ-015 SHALL implement the states IDLE, REQUEST, BEGIN, READ, WRITE, END, ERROR.
REQ-016 IDLE->REQUEST SHALL occur on a start with blockSize!=0; a start with blockSize=0 SHALL leave the FSM in IDLE, with busy held at 0 and error cleared.
REQ-017 In REQUEST the block SHALL hold requestBus=1 until busGrant=1, then go to BEGIN.
REQ-018 BEGIN SHALL last one cycle, asserting beginTransaction, driving the current bus address on addressData, setting burstSize=min(burstLen, remaining-1) and readNotWrite=1 for bus-to-memory.
REQ-019 In READ, each dataValidIn=1 SHALL write dataIn to memAddr with memWe=1 and increment memAddr and the word count.
REQ-020 In READ, endTransactionIn=1 SHALL move the FSM to END.
REQ-021 In WRITE, the block SHALL prefetch from memory so that dataValidOut carries valid data every cycle in which busyIn=0.
REQ-022 In WRITE, busyIn=1 SHALL hold data and addresses stable with no word lost.
REQ-023 After the last burst word in WRITE, the block SHALL pulse endTransactionOut for one cycle and move to END.
REQ-024 END SHALL drop requestBus and advance busStart by 4 x words moved.
REQ-025 END SHALL return to REQUEST while words remain, and to IDLE with busy=0 otherwise.
REQ-026 memAddr SHALL wrap modulo 2^MEM_AW, with 511 followed by 0; the bus address SHALL wrap modulo 2^32.
REQ-027 busErrorIn=1 in any non-IDLE state SHALL abort the transfer: drop all bus outputs the next cycle, set error=1, pass through ERROR for one cycle, then go to IDLE; error SHALL clear on the next accepted start.
REQ-028 busy SHALL equal 1 in every state except IDLE.
REQ-029 All bus outputs SHALL be 0 whenever the block does not hold the grant.

Reset
REQ-030 reset low SHALL immediately force IDLE, clear every configuration register, the counters, busy and error, and drive memWe and all bus outputs to 0, including mid-transfer.
REQ-031 After reset is released, the first rising clock edge SHALL be able to accept a configuration write.

Verification
REQ-032 Bus-to-memory: busStart=0x1000, memStart=1, blockSize=4, burstLen=3, control=1, and a slave returning 0xA0..0xA3 -> memory words 1..4 = 0xA0..0xA3, one burst of burstSize=3, busy returns to 0.
REQ-033 Memory-to-bus with stall: memory words 2..9 = 0x11..0x18, blockSize=8, burstLen=3, busyIn high for 3 cycles mid-burst -> two bursts at 0x2000 and 0x2010, all 8 words in order, no duplicate or lost word.
REQ-034 Wrap and truncation: memStart=510, blockSize=5, burstLen=255 -> single burst with burstSize=4 and memory writes to 510, 511, 0, 1, 2.
REQ-035 Error: busErrorIn pulsed during the 2nd word of a read -> requestBus is 0 the next cycle, cfgResult(5)=0x2, and a later start clears the error bit.
REQ-036 Reset and ignore: a start while busy is ignored; reset asserted mid-WRITE -> all outputs 0 asynchronously; after release the status reads 0 and a zero-size start leaves busy=0.
